vdecoder: RTL
=============

# vdecoder

Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code produced by `vencoder`. It consumes the encoder's serial coded stream, one coded bit per `Clock`, and recovers the original data bits. It uses 4-state add-compare-select (ACS) with register-exchange survivor paths and emits one decoded bit per symbol pair after a fixed traceback depth. It sits at the receive end of the PRML channel, directly downstream of the encoder/channel model.

## Interface
- `TB_DEPTH`, 16: survivor path length in trellis steps (≥4).
- `PM_W`, 4: path-metric width in bits (≥4).
- `Clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in`  in  1  serial coded bit. First bit after reset release is c0 of symbol 1, then c1, then alternating.
- `out`  out  1  decoded data bit; held between updates.
- `out_valid`  out  1  one-cycle pulse when `out` carries a new decoded bit.

## Operation
- Code definition. State s={s1,s0} holds the previous inputs; s1 is the most recent.
  - For input u: c0=u^s1^s0 (g=7), c1=u^s0 (g=5).
  - Transmission order is c0 then c1.
  - Next state is {u,s1}. The encoder starts in state 00.
- Deserialiser. `phase` toggles every clock.
  - phase 0: register `in` as r0.
  - phase 1: r1=`in`, and the ACS step executes on this same edge using {r0, r1}.
- Branch metric: Hamming distance between {r0,r1} and the expected {c0,c1}. Range 0–2.
- ACS, for each next state ns={a,b}:
  - Predecessors are p0={b,0} and p1={b,1}, both with input u=a.
  - cand_i = PM[p_i] + BM(p_i,a).
  - Select the smaller candidate. On a tie, select p0.
- Normalisation: after ACS, subtract the minimum of the four new metrics from all four, then saturate at 2^PM_W−1.
- Survivors: SP[ns] ← {SP[selected pred][TB_DEPTH-2:0], a}.
- Best state: the one with the lowest new metric. On a tie, the lowest state index wins.
- Output: `out` ← new SP[best][TB_DEPTH-1].
- Step counter: counts completed ACS steps and saturates at TB_DEPTH. `out_valid` fires on every ACS edge where count (after increment) ≥ TB_DEPTH.

## Timing
- Reset (asynchronous, active-low) sets:
  - phase=0, r0=0, count=0
  - PM[00]=0, PM[01]=PM[10]=PM[11]=8
  - all SP=0
  - `out`=0, `out_valid`=0
- Reset is honoured at any point, including mid-pair or mid-stream. The next post-release bit is treated as c0 of a new symbol 1 starting from state 00.
- An ACS step occurs on every 2nd clock edge after release: edges 2, 4, 6, …
- Latency: data bit j (the j-th symbol pair) is output on the ACS edge of pair j+TB_DEPTH−1.
  - The first `out_valid` is on edge 2·TB_DEPTH after release. Default: edge 32.
- `out_valid` is high for exactly 1 cycle, then low for 1 cycle, repeating in steady state.
- `out` changes only on `out_valid` edges.
- No input flow control. The stream is continuous, matching the encoder.

## Test plan
- All-zero stream, 64 pairs:
  - `out_valid` first asserts at edge 32, then every 2 clocks.
  - All decoded bits are 0.
  - Metrics stay bounded with no saturation glitch.
- Known vector: data 1,0,1,1,0,0 encodes to stream 11 10 00 01 01 11, followed by zero padding.
  - The first 6 decoded bits are 1,0,1,1,0,0.
  - They appear on edges 32, 34, … 42.
- Single error: flip the c1 of pair 3 in the vector above.
  - Decoded output is identical to the error-free case.
- Isolated errors: 200 random bits driven through `vencoder`, with one bit flipped every 12 pairs.
  - Zero decoded bit errors versus the input, compared with a delay of TB_DEPTH−1 pairs.
- Reset mid-operation: assert `reset` low for 7 ns, asynchronously between edges, during phase 1 at pair 20.
  - `out`=0, `out_valid`=0, and metrics return to init immediately.
  - After release, decoding restarts and the first `out_valid` is again at edge 32.
- Back-to-back `vencoder` loopback, with random input changing every 2 clocks for 1000 cycles:
  - Decoded stream equals the input stream delayed by TB_DEPTH−1 pairs.
  - `out_valid` never asserts on phase-0 edges.

Source files
------------

// File: rtl/vdecoder.sv
`default_nettype none
// ============================================================================
//  Module      : vdecoder
//  Description : Hard-decision Viterbi decoder for the rate-1/2, K=3
//                convolutional code (g0=7, g1=5). Deserialises the coded
//                stream into symbol pairs. Runs a 4-state add-compare-select
//                step per pair and keeps survivors by register exchange.
//                Emits one decoded bit per pair after TB_DEPTH steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module vdecoder #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 4
) (
    input  logic Clock,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic out_valid
);

    localparam int              c_CW      = $clog2(TB_DEPTH + 1);
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(TB_DEPTH);
    localparam logic [PM_W-1:0] c_PM_MAX  = '1;
    localparam logic [PM_W-1:0] c_PM_INIT = PM_W'(8);

    // Hamming distance between the received pair and an expected pair
    function automatic logic [1:0] bm(input logic r0, input logic r1,
                                      input logic e0, input logic e1);
        return {1'b0, r0 ^ e0} + {1'b0, r1 ^ e1};
    endfunction

    logic                r_phase;
    logic                r_r0;
    logic [c_CW-1:0]     r_count;
    logic [PM_W-1:0]     r_pm [4];
    // The oldest survivor bit is consumed as the output on the step it is
    // formed, so only TB_DEPTH-1 bits per path need to be stored.
    logic [TB_DEPTH-2:0] r_sp [4];

    logic [PM_W:0]       w_cand0  [4];
    logic [PM_W:0]       w_cand1  [4];
    logic [PM_W:0]       w_raw    [4];
    logic [PM_W:0]       w_diff   [4];
    logic [PM_W-1:0]     w_pm_nxt [4];
    logic [TB_DEPTH-1:0] w_sp_nxt [4];
    logic [3:0]          w_sel;
    logic [PM_W:0]       w_min;
    logic [1:0]          w_best;
    logic [c_CW-1:0]     w_cnt_nxt;
    logic                w_valid;

    // Per next state ns={a,b}: predecessors {b,0} and {b,1}, both on input a.
    // Expected symbol from predecessor {b,x}: c0=a^b^x, c1=a^x.
    for (genvar gi = 0; gi < 4; gi++) begin : g_acs
        localparam logic c_A = 1'((gi >> 1) & 1);
        localparam logic c_B = 1'(gi & 1);

        assign w_cand0[gi] = {1'b0, r_pm[{c_B, 1'b0}]}
                           + {{(PM_W-1){1'b0}}, bm(r_r0, in, c_A ^ c_B, c_A)};
        assign w_cand1[gi] = {1'b0, r_pm[{c_B, 1'b1}]}
                           + {{(PM_W-1){1'b0}}, bm(r_r0, in, ~(c_A ^ c_B), ~c_A)};
        // Ties go to the predecessor with low bit 0
        assign w_sel[gi]    = (w_cand1[gi] < w_cand0[gi]);
        assign w_raw[gi]    = w_sel[gi] ? w_cand1[gi] : w_cand0[gi];
        assign w_diff[gi]   = w_raw[gi] - w_min;
        assign w_pm_nxt[gi] = w_diff[gi][PM_W] ? c_PM_MAX : w_diff[gi][PM_W-1:0];
        assign w_sp_nxt[gi] = {r_sp[{c_B, w_sel[gi]}], c_A};
    end

    // Minimum new metric and the lowest-index state that holds it
    always_comb begin
        w_min  = w_raw[0];
        w_best = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (w_raw[i] < w_min) begin
                w_min  = w_raw[i];
                w_best = 2'(i);
            end
        end
    end

    assign w_cnt_nxt = (r_count == c_DEPTH) ? r_count : r_count + 1'b1;
    assign w_valid   = (w_cnt_nxt >= c_DEPTH);

    // Deserialise on phase 0, run the ACS step and update output on phase 1
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_phase   <= 1'b0;
            r_r0      <= 1'b0;
            r_count   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_pm[i] <= (i == 0) ? '0 : c_PM_INIT;
                r_sp[i] <= '0;
            end
        end else begin
            r_phase   <= ~r_phase;
            out_valid <= 1'b0;
            if (!r_phase) begin
                r_r0 <= in;
            end else begin
                r_count <= w_cnt_nxt;
                for (int i = 0; i < 4; i++) begin
                    r_pm[i] <= w_pm_nxt[i];
                    r_sp[i] <= w_sp_nxt[i][TB_DEPTH-2:0];
                end
                if (w_valid) begin
                    out_valid <= 1'b1;
                    out       <= w_sp_nxt[w_best][TB_DEPTH-1];
                end
            end
        end
    end

endmodule
`default_nettype wire
